// File: rtl/cache_axi_pkg.sv
// Shared constants and state encoding for the cache-line AXI controller.
// AXI burst attributes are fixed for a full-line transfer.
package cache_axi_pkg;

   localparam int ADDR_WIDTH       = 32;
   localparam int AXI_DATA_WIDTH   = 32;
   localparam int FIFO_WIDTH       = 512;
   localparam int BEATS            = FIFO_WIDTH / AXI_DATA_WIDTH;
   localparam int LINE_OFFSET_BITS = $clog2(FIFO_WIDTH / 8);

   localparam logic [7:0] AXI_LEN        = 8'(BEATS - 1);
   localparam logic [2:0] AXI_SIZE       = 3'($clog2(AXI_DATA_WIDTH / 8));
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB_AW,
      S_WB_W,
      S_WB_B,
      S_RD_AR,
      S_RD_R,
      S_DONE
   } t_line_state;

   // SLVERR and DECERR both carry resp[1]; decode the full code so every bit is used.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

// File: rtl/cache_line_axi_ctrl_if.sv
// AXI handshake/address/response signals between the line controller (master)
// and the AXI port (slave). Data buses are wired to the FIFO outside this bundle.
interface cache_line_axi_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;

   logic                  wvalid;
   logic                  wready;
   logic                  wlast;

   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;

   logic                  rvalid;
   logic                  rready;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wlast,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rresp,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wlast,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rresp,
      input  rready
   );

endinterface

// File: rtl/cache_line_axi_ctrl_beat_counter.sv
// Burst beat counter: cleared on the address handshake, bumped per data beat,
// flags the final beat of a line.
module beat_counter #(
   parameter int BEATS = 16
) (
   input  logic clk,
   input  logic arst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_last
);

   localparam int W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear)
         cnt_d = '0;
      else if (i_inc)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign o_last = (cnt_q == W'(BEATS - 1));

endmodule

// File: rtl/cache_line_axi_ctrl.sv
// Sequences the cache-line shift FIFO against one AXI burst per operation:
// dirty write-back (FIFO -> W) has priority over line fill (R -> FIFO).
module cache_line_axi_ctrl
   import cache_axi_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int FIFO_WIDTH     = 512
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  i_wb_req,
   input  logic                  i_fill_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic                  o_fifo_write_en,
   output logic                  o_fifo_start_read,
   output logic                  o_fifo_start_write,
   cache_line_axi_ctrl_if.master axi
);

   localparam int N_BEATS  = FIFO_WIDTH / AXI_DATA_WIDTH;
   localparam int OFF_BITS = $clog2(FIFO_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

   t_line_state           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  err_q, err_d;
   logic                  op_wb_q, op_wb_d;

   logic cnt_clr, cnt_inc, cnt_last;
   logic awvalid, wvalid, wlast, bready, arvalid, rready;
   logic write_en, start_read, start_write, done;

   beat_counter #(.BEATS(N_BEATS)) u_beat_cnt (
      .clk     (clk),
      .arst    (arst),
      .i_clear (cnt_clr),
      .i_inc   (cnt_inc),
      .o_last  (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      err_d       = err_q;
      op_wb_d     = op_wb_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      awvalid     = 1'b0;
      wvalid      = 1'b0;
      wlast       = 1'b0;
      bready      = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      write_en    = 1'b0;
      start_read  = 1'b0;
      start_write = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Start flags low here lets the FIFO parallel-load the line each cycle.
            if (i_wb_req) begin
               addr_d  = i_addr & ~OFF_MASK;
               err_d   = 1'b0;
               op_wb_d = 1'b1;
               state_d = S_WB_AW;
            end else if (i_fill_req) begin
               addr_d  = i_addr & ~OFF_MASK;
               err_d   = 1'b0;
               op_wb_d = 1'b0;
               state_d = S_RD_AR;
            end
         end
         S_WB_AW: begin
            start_write = 1'b1;
            awvalid     = 1'b1;
            if (axi.awready) begin
               cnt_clr = 1'b1;
               state_d = S_WB_W;
            end
         end
         S_WB_W: begin
            start_write = 1'b1;
            wvalid      = 1'b1;
            wlast       = cnt_last;
            if (axi.wready) begin
               write_en = 1'b1;
               cnt_inc  = 1'b1;
               if (cnt_last)
                  state_d = S_WB_B;
            end
         end
         S_WB_B: begin
            start_write = 1'b1;
            bready      = 1'b1;
            if (axi.bvalid) begin
               err_d   = err_q | resp_is_err(axi.bresp);
               state_d = S_DONE;
            end
         end
         S_RD_AR: begin
            start_read = 1'b1;
            arvalid    = 1'b1;
            if (axi.arready) begin
               cnt_clr = 1'b1;
               state_d = S_RD_R;
            end
         end
         S_RD_R: begin
            start_read = 1'b1;
            rready     = 1'b1;
            write_en   = axi.rvalid;
            if (axi.rvalid) begin
               err_d   = err_q | resp_is_err(axi.rresp);
               cnt_inc = 1'b1;
               if (cnt_last)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Hold the finished op's mode so the line is stable while it is captured.
            done        = 1'b1;
            start_write = op_wb_q;
            start_read  = ~op_wb_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         err_q   <= 1'b0;
         op_wb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         op_wb_q <= op_wb_d;
      end
   end

   assign o_busy             = (state_q != S_IDLE);
   assign o_done             = done;
   assign o_error            = err_q;
   assign o_fifo_write_en    = write_en;
   assign o_fifo_start_read  = start_read;
   assign o_fifo_start_write = start_write;

   assign axi.awvalid = awvalid;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = AXI_LEN;
   assign axi.awsize  = AXI_SIZE;
   assign axi.awburst = AXI_BURST_INCR;
   assign axi.wvalid  = wvalid;
   assign axi.wlast   = wlast;
   assign axi.bready  = bready;
   assign axi.arvalid = arvalid;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = AXI_LEN;
   assign axi.arsize  = AXI_SIZE;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.rready  = rready;

endmodule

// File: tb/tb_cache_line_axi_ctrl.sv
// Directed bench: acts as AXI slave and cache-line shift FIFO around the controller.
module tb_cache_line_axi_ctrl;

   logic        clk;
   logic        arst;
   logic        i_wb_req, i_fill_req;
   logic [31:0] i_addr;
   logic        o_busy, o_done, o_error;
   logic        o_fifo_write_en, o_fifo_start_read, o_fifo_start_write;

   int checks = 0;
   int failures = 0;

   cache_line_axi_ctrl_if #(.ADDR_WIDTH(32)) axi ();

   cache_line_axi_ctrl dut (
      .clk                (clk),
      .arst               (arst),
      .i_wb_req           (i_wb_req),
      .i_fill_req         (i_fill_req),
      .i_addr             (i_addr),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_error            (o_error),
      .o_fifo_write_en    (o_fifo_write_en),
      .o_fifo_start_read  (o_fifo_start_read),
      .o_fifo_start_write (o_fifo_start_write),
      .axi                (axi.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shift FIFO: parallel load when idle, shift right one word per write_en.
   logic [511:0] fifo_q, line_in;
   logic [31:0]  rdata;
   logic [31:0]  wdata;
   always @(posedge clk) begin
      if (!o_fifo_start_read && !o_fifo_start_write)
         fifo_q <= line_in;
      else if (o_fifo_write_en)
         fifo_q <= {(o_fifo_start_read ? rdata : 32'h0), fifo_q[511:32]};
   end
   assign wdata = fifo_q[31:0];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_axi();
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00;
   endtask

   task automatic run_wb(input logic [31:0] addr, input int aw_stall,
                         input logic [1:0] bresp_v, input logic exp_err);
      int beat = 0;
      int stall = 0;
      int cyc = 0;
      bit done_seen = 1'b0;
      bit wtog = 1'b1;
      logic [31:0] exp_addr;
      exp_addr = addr & 32'hFFFF_FFC0;
      i_wb_req = 1'b1; i_addr = addr;
      @(posedge clk); #1;
      while (!done_seen && cyc < 200) begin
         axi.awready = axi.awvalid && (stall >= aw_stall);
         axi.wready  = axi.wvalid && wtog;
         axi.bvalid  = axi.bready;
         axi.bresp   = bresp_v;
         #2;
         chk("wb_no_arvalid", axi.arvalid, 1'b0);
         if (axi.awvalid) begin
            chk("wb_awaddr", axi.awaddr, exp_addr);
            chk("wb_no_wvalid_before_aw", axi.wvalid, 1'b0);
            chk("wb_err_cleared", o_error, 1'b0);
            if (stall == 0) chk("wb_awlen_size_burst", {axi.awlen, axi.awsize, axi.awburst}, {8'd15, 3'd2, 2'b01});
            stall++;
         end
         if (axi.wvalid) begin
            chk("wb_write_en", o_fifo_write_en, axi.wready);
            if (axi.wready) begin
               chk("wb_wdata", wdata, 32'hA000_0000 + 32'(beat));
               chk("wb_wlast", axi.wlast, (beat == 15));
               beat++;
            end
            wtog = !wtog;
         end
         if (o_done) begin
            done_seen = 1'b1;
            chk("wb_beats", beat, 16);
            chk("wb_error", o_error, exp_err);
            chk("wb_done_start_write", o_fifo_start_write, 1'b1);
            i_wb_req = 1'b0;
         end
         cyc++;
         @(posedge clk); #1;
      end
      if (!done_seen) chk("wb_timeout", done_seen, 1'b1);
      idle_axi();
   endtask

   task automatic run_fill(input logic [31:0] addr, input int bad_beat, input logic exp_err);
      int beat = 0;
      int cyc = 0;
      int last_cyc = -10;
      bit done_seen = 1'b0;
      logic [511:0] exp_line;
      for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = 32'(k);
      i_fill_req = 1'b1; i_addr = addr;
      @(posedge clk); #1;
      while (!done_seen && cyc < 200) begin
         axi.arready = axi.arvalid;
         axi.rvalid  = axi.rready;
         rdata       = 32'(beat);
         axi.rresp   = (beat == bad_beat) ? 2'b10 : 2'b00;
         #2;
         chk("fill_no_awvalid", axi.awvalid, 1'b0);
         if (axi.arvalid) begin
            chk("fill_araddr", axi.araddr, addr & 32'hFFFF_FFC0);
            chk("fill_arlen", axi.arlen, 8'd15);
            chk("fill_err_cleared", o_error, 1'b0);
         end
         if (axi.rready) begin
            chk("fill_write_en", o_fifo_write_en, 1'b1);
            chk("fill_start_read", o_fifo_start_read, 1'b1);
            last_cyc = cyc;
            beat++;
         end
         if (o_done) begin
            done_seen = 1'b1;
            chk("fill_beats", beat, 16);
            chk("fill_done_after_last", cyc - last_cyc, 1);
            chk("fill_done_start_read", o_fifo_start_read, 1'b1);
            chk("fill_line", fifo_q, exp_line);
            chk("fill_error", o_error, exp_err);
            i_fill_req = 1'b0;
         end
         cyc++;
         @(posedge clk); #1;
      end
      if (!done_seen) chk("fill_timeout", done_seen, 1'b1);
      idle_axi();
   endtask

   initial begin
      int beat;
      int cyc;
      arst = 1'b1; i_wb_req = 1'b0; i_fill_req = 1'b0; i_addr = '0; rdata = '0;
      for (int k = 0; k < 16; k++) line_in[32*k +: 32] = 32'hA000_0000 + 32'(k);
      idle_axi();
      #1;
      chk("reset_outputs",
          {o_busy, o_done, o_error, o_fifo_write_en, o_fifo_start_read, o_fifo_start_write,
           axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, 12'h0);
      chk("reset_addr", {axi.awaddr, axi.araddr}, 64'h0);
      @(posedge clk); @(negedge clk);
      arst = 1'b0;
      @(posedge clk); #1;

      // Plain fill, then plain write-back with toggling wready.
      run_fill(32'h1234_5678, -1, 1'b0);
      run_wb(32'h8000_0ABC, 0, 2'b00, 1'b0);

      // awready stalled 5 cycles, SLVERR on B.
      run_wb(32'h0000_107F, 5, 2'b10, 1'b1);

      // SLVERR on R beat 3; the new op clears the previous error first.
      run_fill(32'h0BAD_F00D, 3, 1'b1);

      // Simultaneous requests: write-back first, one idle cycle, then fill.
      i_fill_req = 1'b1;
      run_wb(32'h4444_4444, 0, 2'b00, 1'b0);
      chk("both_idle_gap_busy", o_busy, 1'b0);
      chk("both_idle_gap_arvalid", axi.arvalid, 1'b0);
      run_fill(32'h5555_5555, -1, 1'b0);

      // Reset during WB_W after five beats.
      i_wb_req = 1'b1; i_addr = 32'h7000_0040;
      @(posedge clk); #1;
      beat = 0; cyc = 0;
      while (beat < 5 && cyc < 50) begin
         axi.awready = axi.awvalid;
         axi.wready  = axi.wvalid;
         #2;
         if (axi.wvalid && axi.wready) beat++;
         cyc++;
         @(posedge clk); #1;
      end
      chk("rst_pre_wvalid", axi.wvalid, 1'b1);
      arst = 1'b1;
      #1;
      chk("rst_mid_outputs",
          {o_busy, o_done, o_error, o_fifo_write_en, o_fifo_start_read, o_fifo_start_write,
           axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, 12'h0);
      chk("rst_mid_addr", axi.awaddr, 32'h0);
      i_wb_req = 1'b0;
      idle_axi();
      @(posedge clk); @(negedge clk);
      arst = 1'b0;
      @(posedge clk); #1;
      run_fill(32'h6000_0000, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
